// File: rtl/phase_frame_decoder.sv
// Byte-stream frame receiver feeding phase_calibration: assembles phase/calibration frames
// and commits them atomically. Define PHASE_FRAME_CHECKSUM_EN for the trailing XOR checksum byte.
module phase_frame_decoder #(
   parameter int          NUM_CHANNELS   = 4,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter logic [7:0]  HDR_PHASE      = 8'hAA,
   parameter logic [7:0]  HDR_CALIB      = 8'hAB
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic [7:0] phases_out [NUM_CHANNELS],
   output logic       phase_calib_en,
   output logic       frame_busy,
   output logic       frame_error
);

   localparam int IDX_W = $clog2(NUM_CHANNELS + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef PHASE_FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             is_calib_q, is_calib_d;
   logic [7:0]       shadow_q [NUM_CHANNELS];
   logic [7:0]       shadow_d [NUM_CHANNELS];
   logic [7:0]       phase_q [NUM_CHANNELS];
   logic [7:0]       phase_d [NUM_CHANNELS];
   logic [7:0]       phases_out_q [NUM_CHANNELS];
   logic [7:0]       phases_out_d [NUM_CHANNELS];
   logic             calib_en_q, calib_en_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [7:0]       frame_s [NUM_CHANNELS];
   logic             commit_s;
`ifdef PHASE_FRAME_CHECKSUM_EN
   logic [7:0]       chk_q, chk_d;
`endif

   // Next-state, frame assembly, timeout and commit logic
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      tmo_d        = tmo_q;
      is_calib_d   = is_calib_q;
      shadow_d     = shadow_q;
      phase_d      = phase_q;
      phases_out_d = phase_q;
      calib_en_d   = 1'b0;
      err_d        = 1'b0;
      commit_s     = 1'b0;
`ifdef PHASE_FRAME_CHECKSUM_EN
      chk_d        = chk_q;
`endif

      // Shadow with the incoming byte merged in; once idx passes the last slot it equals shadow_q.
      frame_s = shadow_q;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (byte_valid && (idx_q == IDX_W'(i))) begin
            frame_s[i] = byte_in;
         end else begin
            frame_s[i] = shadow_q[i];
         end
      end

      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (byte_valid) begin
               if ((byte_in == HDR_PHASE) || (byte_in == HDR_CALIB)) begin
                  is_calib_d = (byte_in == HDR_CALIB);
                  idx_d      = '0;
                  state_d    = ST_PAYLOAD;
`ifdef PHASE_FRAME_CHECKSUM_EN
                  chk_d      = byte_in;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               idx_d = '0;
            end
         end
         ST_PAYLOAD: begin
            if (byte_valid) begin
               tmo_d    = '0;
               shadow_d = frame_s;
               idx_d    = idx_q + IDX_W'(1);
`ifdef PHASE_FRAME_CHECKSUM_EN
               chk_d    = chk_step(chk_q, byte_in);
               if (idx_q == LAST_IDX) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_PAYLOAD;
               end
`else
               if (idx_q == LAST_IDX) begin
                  commit_s = 1'b1;
               end else begin
                  state_d = ST_PAYLOAD;
               end
`endif
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               for (int i = 0; i < NUM_CHANNELS; i++) shadow_d[i] = 8'h00;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
`ifdef PHASE_FRAME_CHECKSUM_EN
         ST_CHECK: begin
            if (byte_valid) begin
               tmo_d = '0;
               if (byte_in == chk_q) begin
                  commit_s = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                  for (int i = 0; i < NUM_CHANNELS; i++) shadow_d[i] = 8'h00;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               for (int i = 0; i < NUM_CHANNELS; i++) shadow_d[i] = 8'h00;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            tmo_d   = '0;
         end
      endcase

      // Calibration frames show for one cycle only and never touch the phase register.
      if (commit_s) begin
         state_d = ST_IDLE;
         for (int i = 0; i < NUM_CHANNELS; i++) shadow_d[i] = 8'h00;
         if (is_calib_q) begin
            phases_out_d = frame_s;
            calib_en_d   = 1'b1;
         end else begin
            phase_d      = frame_s;
            phases_out_d = frame_s;
         end
      end else begin
         calib_en_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         tmo_q      <= '0;
         is_calib_q <= 1'b0;
         calib_en_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shadow_q[i]     <= 8'h00;
            phase_q[i]      <= 8'h00;
            phases_out_q[i] <= 8'h00;
         end
`ifdef PHASE_FRAME_CHECKSUM_EN
         chk_q      <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         tmo_q        <= tmo_d;
         is_calib_q   <= is_calib_d;
         calib_en_q   <= calib_en_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         shadow_q     <= shadow_d;
         phase_q      <= phase_d;
         phases_out_q <= phases_out_d;
`ifdef PHASE_FRAME_CHECKSUM_EN
         chk_q        <= chk_d;
`endif
      end
   end

   assign phases_out     = phases_out_q;
   assign phase_calib_en = calib_en_q;
   assign frame_busy     = busy_q;
   assign frame_error    = err_q;

endmodule

// File: tb/tb_phase_frame_decoder.sv
// Directed self-checking bench for phase_frame_decoder (timeout shortened to 8 clocks).
module tb_phase_frame_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic [7:0] phases_out [4];
   logic       phase_calib_en;
   logic       frame_busy;
   logic       frame_error;

   int total = 0;
   int bad   = 0;
   logic calib_seen;

   phase_frame_decoder #(
      .NUM_CHANNELS  (4),
      .TIMEOUT_CYCLES(8),
      .HDR_PHASE     (8'hAA),
      .HDR_CALIB     (8'hAB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .phases_out    (phases_out),
      .phase_calib_en(phase_calib_en),
      .frame_busy    (frame_busy),
      .frame_error   (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (phase_calib_en === 1'b1) calib_seen = 1'b1;
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk();
      return {phases_out[0], phases_out[1], phases_out[2], phases_out[3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      byte_in    = 8'h00;
   endtask

   // Full frame including trailing checksum when the feature is built in
   task automatic send_frame(input logic [7:0] h, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      send(h); send(b0); send(b1); send(b2); send(b3);
`ifdef PHASE_FRAME_CHECKSUM_EN
      send(h ^ b0 ^ b1 ^ b2 ^ b3);
`endif
   endtask

   initial begin
      rst_n      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      calib_seen = 1'b0;
      tick(); tick();
      chk_eq("rst_phases", pk(), 32'h0);
      chk_eq("rst_calib", {31'd0, phase_calib_en}, 32'd0);
      chk_eq("rst_busy", {31'd0, frame_busy}, 32'd0);
      chk_eq("rst_err", {31'd0, frame_error}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Phase frame, busy tracked byte by byte
      send(8'hAA);
      chk_eq("busy_after_hdr", {31'd0, frame_busy}, 32'd1);
      send(8'h10); send(8'h20); send(8'h30);
      chk_eq("busy_mid", {31'd0, frame_busy}, 32'd1);
      chk_eq("no_partial", pk(), 32'h0);
      send(8'h40);
`ifdef PHASE_FRAME_CHECKSUM_EN
      chk_eq("busy_check", {31'd0, frame_busy}, 32'd1);
      send(8'hEA);
`endif
      chk_eq("phase_commit", pk(), 32'h10203040);
      chk_eq("busy_after_commit", {31'd0, frame_busy}, 32'd0);
      chk_eq("phase_no_calib", {31'd0, calib_seen}, 32'd0);

      // Calibration frame shows for exactly one cycle
      send_frame(8'hAB, 8'h01, 8'h02, 8'h03, 8'h04);
      chk_eq("calib_vals", pk(), 32'h01020304);
      chk_eq("calib_en_hi", {31'd0, phase_calib_en}, 32'd1);
      tick();
      chk_eq("calib_revert", pk(), 32'h10203040);
      chk_eq("calib_en_lo", {31'd0, phase_calib_en}, 32'd0);

      // Bad header
      send(8'h55);
      chk_eq("bad_hdr_err", {31'd0, frame_error}, 32'd1);
      chk_eq("bad_hdr_busy", {31'd0, frame_busy}, 32'd0);
      chk_eq("bad_hdr_phases", pk(), 32'h10203040);
      tick();
      chk_eq("bad_hdr_err_pulse", {31'd0, frame_error}, 32'd0);
      calib_seen = 1'b0;
      send_frame(8'hAA, 8'h05, 8'h06, 8'h07, 8'h08);
      chk_eq("after_bad_commit", pk(), 32'h05060708);
      chk_eq("after_bad_err", {31'd0, frame_error}, 32'd0);

      // Timeout after 8 idle clocks
      send(8'hAA); send(8'h11); send(8'h22);
      repeat (7) tick();
      chk_eq("tmo_not_yet_err", {31'd0, frame_error}, 32'd0);
      chk_eq("tmo_not_yet_busy", {31'd0, frame_busy}, 32'd1);
      tick();
      chk_eq("tmo_err", {31'd0, frame_error}, 32'd1);
      chk_eq("tmo_busy", {31'd0, frame_busy}, 32'd0);
      chk_eq("tmo_phases", pk(), 32'h05060708);
      tick();
      chk_eq("tmo_err_pulse", {31'd0, frame_error}, 32'd0);

      // Byte on the exact timeout cycle keeps the frame alive
      send(8'hAA); send(8'h11); send(8'h22);
      repeat (7) tick();
      send(8'h33);
      chk_eq("tmo_edge_err", {31'd0, frame_error}, 32'd0);
      chk_eq("tmo_edge_busy", {31'd0, frame_busy}, 32'd1);
      send(8'h44);
`ifdef PHASE_FRAME_CHECKSUM_EN
      send(8'hEE);
`endif
      chk_eq("tmo_edge_commit", pk(), 32'h11223344);
      chk_eq("phase_frames_no_calib", {31'd0, calib_seen}, 32'd0);

      // Reset mid-frame
      send(8'hAA); send(8'h11);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_eq("midrst_phases", pk(), 32'h0);
      chk_eq("midrst_busy", {31'd0, frame_busy}, 32'd0);
      chk_eq("midrst_err", {31'd0, frame_error}, 32'd0);
      send(8'h33);
      chk_eq("midrst_33_err", {31'd0, frame_error}, 32'd1);
      chk_eq("midrst_33_busy", {31'd0, frame_busy}, 32'd0);
      send(8'h44);
      chk_eq("midrst_44_err", {31'd0, frame_error}, 32'd1);
      chk_eq("midrst_44_phases", pk(), 32'h0);

`ifdef PHASE_FRAME_CHECKSUM_EN
      tick();
      send(8'hAA); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hAE);
      chk_eq("cks_ok_commit", pk(), 32'h01020304);
      chk_eq("cks_ok_err", {31'd0, frame_error}, 32'd0);
      send(8'hAA); send(8'h09); send(8'h09); send(8'h09); send(8'h09); send(8'hAF);
      chk_eq("cks_bad_err", {31'd0, frame_error}, 32'd1);
      chk_eq("cks_bad_phases", pk(), 32'h01020304);
      chk_eq("cks_bad_busy", {31'd0, frame_busy}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
